// File: rtl/adder4bit_seq_ctrl.sv
// Nibble-serial multi-precision adder: one 4-bit adder stepped over NIBBLES slices.
// Define ADDSEQ_SUB_EN to add the `sub` port (a-b via ~b with forced carry-in).

module adder4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module adder4bit_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef ADDSEQ_SUB_EN
   input  logic                 sub,
`endif
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf
);
   localparam int W  = 4*NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nx;
   logic [W-1:0]    a_q, b_q, sum_q;
   logic            c_q, cout_q, ovf_q;
   logic [IW-1:0]   idx;
   logic [IW+1:0]   base;
   logic [3:0]      s_nib;
   logic            co_nib;
   logic [W-1:0]    b_in;
   logic            c_in;
   logic            accept;

`ifdef ADDSEQ_SUB_EN
   // Subtract as a + ~b + 1; carry-out then reads as "no borrow".
   assign b_in = sub ? ~b : b;
   assign c_in = sub ? 1'b1 : cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   assign base   = {idx, 2'b00};
   assign accept = (state == IDLE) && start;

   adder4bit u_add (
      .a  (a_q[base +: 4]),
      .b  (b_q[base +: 4]),
      .ci (c_q),
      .s  (s_nib),
      .co (co_nib)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (idx == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= 1'b0;
         sum_q  <= '0;
         idx    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b_in;
         c_q   <= c_in;
         sum_q <= '0;
         idx   <= '0;
      end else if (state == RUN) begin
         sum_q[base +: 4] <= s_nib;
         c_q              <= co_nib;
         if (idx == LAST) begin
            cout_q <= co_nib;
            // b_q already holds ~b when subtracting, so one rule covers both modes
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (s_nib[3] != a_q[W-1]);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule
